cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 block in the memory stage; consumes the M_* bundle produced by the E→M pipeline register.
- Holds SR, Cause, EPC and PRId, and arbitrates hardware interrupts against the exception code carried down the pipe.
- Drives `req`, which flushes the pipeline registers to the handler entry, and `EPC_out`, which supplies the eret return target.

Parameters:
PRID, 32'h0000_2530, value returned on reads of CP0 register 15
HWINT_W, 6, number of hardware interrupt lines (mapped to IP/IM bits 15:10)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
M_PC  input  32  PC of the instruction in M; valid for bubbles too (the pipeline carries the PC through)
M_BD  input  1  instruction in M sits in a branch delay slot
M_ExcCode  input  5  exception code from earlier stages; 0 = none
M_mtc0  input  1  mtc0 in M
M_eret  input  1  eret in M
M_rd  input  5  CP0 register number for mtc0/mfc0
M_RD2  input  32  forwarded mtc0 write data
HWInt  input  6  external interrupt lines, level-sensitive
cp0_rdata  output  32  combinational read of the register selected by M_rd; 0 for unimplemented numbers
req  output  1  exception/interrupt taken this cycle (combinational)
EPC_out  output  32  current EPC register value

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1] and IE[0] are writable; all other bits read 0.
  - Cause (13): BD[31], IP[15:10] and ExcCode[6:2]; read-only to mtc0.
  - EPC (14): full 32 bits writable.
  - PRId (15): constant PRID.
- Reset (async, active-high): SR = 0, Cause = 0, EPC = 0. Outputs follow, so `req` = 0 and `EPC_out` = 0.
- Request generation (combinational):
  - int_req = |(HWInt & SR.IM) & SR.IE & !SR.EXL
  - exc_req = (M_ExcCode != 0) & !SR.EXL
  - req = int_req | exc_req
- Priority: an interrupt beats an exception in the same cycle.
- Cause.IP is loaded with HWInt on every clock edge, regardless of any other event.
- On a clock edge with `req` = 1:
  - SR.EXL <= 1
  - Cause.ExcCode <= int_req ? 0 : M_ExcCode
  - Cause.BD <= M_BD
  - EPC <= M_BD ? M_PC-4 : M_PC
  - Any concurrent mtc0 or eret is discarded.
- On a clock edge with `req` = 0:
  - eret clears SR.EXL.
  - mtc0 writes M_RD2 into SR (masked to writable bits) or EPC when M_rd is 12 or 14.
  - Writes to any other register number are ignored.
  - mtc0 and eret are never both asserted; if they are, eret is applied and the write is dropped.
- Latency:
  - `req` is same-cycle.
  - Register updates are visible on `cp0_rdata` and `EPC_out` the cycle after the edge.
  - An mfc0 in M one cycle after an mtc0 reads the new value.
- While EXL = 1, neither interrupts nor exceptions are taken: nested events are masked and nothing latches.
- Reset asserted mid-handler clears EXL immediately, without waiting for a clock edge.
- Arithmetic: M_PC-4 is modulo 2^32; 32'h0 in a delay slot gives EPC = 32'hFFFF_FFFC.

Optional Feature:
- Macro: CP0_BADVADDR_EN.
- When defined:
  - Adds input `M_badvaddr` [31:0] and register BadVAddr (8), readable via `cp0_rdata` and read-only to mtc0.
  - BadVAddr loads `M_badvaddr` on a taken exception whose ExcCode is 4 (AdEL) or 5 (AdES).
  - BadVAddr keeps its value on interrupts and on all other codes, and resets to 0.
- When undefined: the port and register are absent, and register 8 reads 0.

Decomposition:
- Shared package (macro header):
  - CP0 register numbers 8/12/13/14/15
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12
  - SR/Cause bit positions
  - the handler entry address 32'h0000_4180 (the `Error_Entry` constant)
- Sub-module `cp0_req_gen`: the combinational int_req/exc_req/priority logic, verified in isolation.

Test Plan:
1. Reset → SR=0, Cause=0, EPC=0, `req`=0; HWInt=6'b000001 with IE=0 → `req` stays 0, Cause.IP=6'b000001 next cycle.
2. mtc0 SR=32'h0000_0401, then HWInt[0]=1 → `req`=1 that cycle; next cycle EXL=1, ExcCode=0, EPC=M_PC (32'h0000_3010).
3. M_ExcCode=12 with M_BD=1 and M_PC=32'h0000_3024 → `req`=1; EPC=32'h0000_3020, Cause.BD=1, ExcCode=12.
4. Interrupt plus M_ExcCode=10 in the same cycle → ExcCode recorded as 0; then, with EXL=1, M_ExcCode=8 → `req`=0 and no register changes.
5. eret with EPC=32'h0000_3020 → EXL cleared next cycle, `EPC_out`=32'h0000_3020; mtc0 coincident with `req` → the write is dropped.
6. CP0_BADVADDR_EN defined: ExcCode=4 with M_badvaddr=32'h0000_0003 → register 8 reads 32'h0000_0003; an async reset pulse between edges → all registers 0 immediately.

Source files
------------

// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, SR/Cause field positions.
// The CP0_BADVADDR_EN macro adds the BadVAddr register (number 8) to cp0_unit.
package cp0_unit_pkg;

   localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_REG_SR       = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_REG_EPC      = 5'd14;
   localparam logic [4:0] CP0_REG_PRID     = 5'd15;

   localparam logic [4:0] EXC_INT     = 5'd0;
   localparam logic [4:0] EXC_ADEL    = 5'd4;
   localparam logic [4:0] EXC_ADES    = 5'd5;
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;

   localparam int SR_IE       = 0;
   localparam int SR_EXL      = 1;
   localparam int SR_IM_LSB   = 10;
   localparam int CAUSE_EXC_LSB = 2;
   localparam int CAUSE_IP_LSB  = 10;
   localparam int CAUSE_BD      = 31;

   // Only IM, EXL and IE survive an mtc0 to SR.
   localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

   localparam logic [31:0] Error_Entry = 32'h0000_4180;

endpackage

// File: rtl/cp0_req_gen.sv
// Combinational interrupt/exception request arbitration for the CP0 unit.
module cp0_req_gen
   import cp0_unit_pkg::*;
#(
   parameter int HWINT_W = 6
) (
   input  logic [HWINT_W-1:0] hwint,
   input  logic [HWINT_W-1:0] im,
   input  logic               ie,
   input  logic               exl,
   input  logic [4:0]         exc_code,
   output logic               int_req,
   output logic               exc_req,
   output logic               req
);

   // Interrupts need a matching unmasked line and global enable; both kinds are blocked inside a handler.
   always_comb begin
      int_req = (|(hwint & im)) & ie & ~exl;
      exc_req = (exc_code != EXC_INT) & ~exl;
      req     = int_req | exc_req;
   end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 in the memory stage: SR, Cause, EPC, PRId and interrupt/exception entry.
// Optional BadVAddr register is enabled by defining CP0_BADVADDR_EN.
module cp0_unit
   import cp0_unit_pkg::*;
#(
   parameter logic [31:0] PRID    = 32'h0000_2530,
   parameter int          HWINT_W = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        M_PC,
   input  logic               M_BD,
   input  logic [4:0]         M_ExcCode,
   input  logic               M_mtc0,
   input  logic               M_eret,
   input  logic [4:0]         M_rd,
   input  logic [31:0]        M_RD2,
   input  logic [HWINT_W-1:0] HWInt,
`ifdef CP0_BADVADDR_EN
   input  logic [31:0]        M_badvaddr,
`endif
   output logic [31:0]        cp0_rdata,
   output logic               req,
   output logic [31:0]        EPC_out
);

   logic [31:0]        sr_q;
   logic               cause_bd_q;
   logic [HWINT_W-1:0] cause_ip_q;
   logic [4:0]         cause_exc_q;
   logic [31:0]        epc_q;
   logic [31:0]        cause_word;
   logic               int_req;
   logic               exc_req;

   cp0_req_gen #(
      .HWINT_W (HWINT_W)
   ) u_req_gen (
      .hwint    (HWInt),
      .im       (sr_q[SR_IM_LSB +: HWINT_W]),
      .ie       (sr_q[SR_IE]),
      .exl      (sr_q[SR_EXL]),
      .exc_code (M_ExcCode),
      .int_req  (int_req),
      .exc_req  (exc_req),
      .req      (req)
   );

   // A taken event wins over any mtc0/eret in the same cycle; eret wins over a coincident mtc0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q        <= '0;
         cause_bd_q  <= 1'b0;
         cause_ip_q  <= '0;
         cause_exc_q <= '0;
         epc_q       <= '0;
      end else begin
         cause_ip_q <= HWInt;
         if (req) begin
            sr_q[SR_EXL] <= 1'b1;
            cause_exc_q  <= (exc_req && !int_req) ? M_ExcCode : EXC_INT;
            cause_bd_q   <= M_BD;
            epc_q        <= M_BD ? (M_PC - 32'd4) : M_PC;
         end else if (M_eret) begin
            sr_q[SR_EXL] <= 1'b0;
         end else if (M_mtc0) begin
            if (M_rd == CP0_REG_SR) begin
               sr_q <= M_RD2 & SR_WMASK;
            end else if (M_rd == CP0_REG_EPC) begin
               epc_q <= M_RD2;
            end
         end
      end
   end

`ifdef CP0_BADVADDR_EN
   logic [31:0] badvaddr_q;

   // Only address-error exceptions capture the faulting address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         badvaddr_q <= '0;
      end else if (exc_req && !int_req &&
                   (M_ExcCode == EXC_ADEL || M_ExcCode == EXC_ADES)) begin
         badvaddr_q <= M_badvaddr;
      end
   end
`endif

   always_comb begin
      cause_word                                = '0;
      cause_word[CAUSE_BD]                      = cause_bd_q;
      cause_word[CAUSE_IP_LSB +: HWINT_W]       = cause_ip_q;
      cause_word[CAUSE_EXC_LSB +: 5]            = cause_exc_q;
   end

   // mfc0 read port; unimplemented register numbers read as zero.
   always_comb begin
      cp0_rdata = '0;
      case (M_rd)
`ifdef CP0_BADVADDR_EN
         CP0_REG_BADVADDR: cp0_rdata = badvaddr_q;
`endif
         CP0_REG_SR:       cp0_rdata = sr_q;
         CP0_REG_CAUSE:    cp0_rdata = cause_word;
         CP0_REG_EPC:      cp0_rdata = epc_q;
         CP0_REG_PRID:     cp0_rdata = PRID;
         default:          cp0_rdata = '0;
      endcase
   end

   assign EPC_out = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed vector table plus an async-reset-mid-handler sequence.
module tb_cp0_unit;

   logic        clk;
   logic        reset;
   logic [31:0] m_pc;
   logic        m_bd;
   logic [4:0]  m_exc_code;
   logic        m_mtc0;
   logic        m_eret;
   logic [4:0]  m_rd;
   logic [31:0] m_rd2;
   logic [5:0]  hw_int;
   logic [31:0] m_badvaddr;
   logic [31:0] cp0_rdata;
   logic        req;
   logic [31:0] epc_out;

   int checks;
   int failures;

`ifdef CP0_BADVADDR_EN
   localparam logic [31:0] BV_EXP = 32'h0000_0003;
`else
   localparam logic [31:0] BV_EXP = 32'h0000_0000;
`endif

   typedef struct {
      logic        mtc0;
      logic        eret;
      logic [4:0]  rd;
      logic [31:0] rd2;
      logic [5:0]  hwint;
      logic [4:0]  exc;
      logic        bd;
      logic [31:0] pc;
      logic [31:0] badv;
      logic        exp_req;
      logic [4:0]  chk_rd;
      logic [31:0] exp_rdata;
      logic [31:0] exp_epc;
   } vec_t;

   vec_t vecs[$];

   cp0_unit #(
      .PRID    (32'h0000_2530),
      .HWINT_W (6)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .M_PC       (m_pc),
      .M_BD       (m_bd),
      .M_ExcCode  (m_exc_code),
      .M_mtc0     (m_mtc0),
      .M_eret     (m_eret),
      .M_rd       (m_rd),
      .M_RD2      (m_rd2),
      .HWInt      (hw_int),
`ifdef CP0_BADVADDR_EN
      .M_badvaddr (m_badvaddr),
`endif
      .cp0_rdata  (cp0_rdata),
      .req        (req),
      .EPC_out    (epc_out)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive a vector mid-cycle, check req before the edge, then read back the chosen register after it.
   task automatic applyStimulus(input int idx, input vec_t v);
      @(negedge clk);
      m_mtc0     = v.mtc0;
      m_eret     = v.eret;
      m_rd       = v.rd;
      m_rd2      = v.rd2;
      hw_int     = v.hwint;
      m_exc_code = v.exc;
      m_bd       = v.bd;
      m_pc       = v.pc;
      m_badvaddr = v.badv;
      #1;
      checkOutput($sformatf("v%0d_req", idx), {31'b0, req}, {31'b0, v.exp_req});
      @(posedge clk);
      #1;
      m_rd = v.chk_rd;
      #1;
      checkOutput($sformatf("v%0d_rdata_r%0d", idx, v.chk_rd), cp0_rdata, v.exp_rdata);
      checkOutput($sformatf("v%0d_epc_out", idx), epc_out, v.exp_epc);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      reset      = 1'b1;
      m_pc       = '0;
      m_bd       = 1'b0;
      m_exc_code = '0;
      m_mtc0     = 1'b0;
      m_eret     = 1'b0;
      m_rd       = '0;
      m_rd2      = '0;
      hw_int     = '0;
      m_badvaddr = '0;

      //                mtc0 eret rd     rd2            hwint  exc    bd   pc             badv           req  chk    exp_rdata      exp_epc
      vecs.push_back(vec_t'{0, 0, 5'd0,  32'h0,         6'h01, 5'd0,  0, 32'h0000_3000, 32'h0,         0, 5'd13, 32'h0000_0400, 32'h0});
      vecs.push_back(vec_t'{1, 0, 5'd12, 32'hFFFF_FFFF, 6'h00, 5'd0,  0, 32'h0000_3004, 32'h0,         0, 5'd12, 32'h0000_FC03, 32'h0});
      vecs.push_back(vec_t'{0, 0, 5'd0,  32'h0,         6'h00, 5'd12, 0, 32'h0000_0100, 32'h0,         0, 5'd14, 32'h0000_0000, 32'h0});
      vecs.push_back(vec_t'{1, 0, 5'd12, 32'h0000_0401, 6'h00, 5'd0,  0, 32'h0000_3008, 32'h0,         0, 5'd12, 32'h0000_0401, 32'h0});
      vecs.push_back(vec_t'{0, 0, 5'd0,  32'h0,         6'h01, 5'd0,  0, 32'h0000_3010, 32'h0,         1, 5'd12, 32'h0000_0403, 32'h0000_3010});
      vecs.push_back(vec_t'{0, 0, 5'd0,  32'h0,         6'h01, 5'd8,  0, 32'h0000_3014, 32'h0,         0, 5'd13, 32'h0000_0400, 32'h0000_3010});
      vecs.push_back(vec_t'{0, 1, 5'd0,  32'h0,         6'h00, 5'd0,  0, 32'h0000_3018, 32'h0,         0, 5'd12, 32'h0000_0401, 32'h0000_3010});
      vecs.push_back(vec_t'{0, 0, 5'd0,  32'h0,         6'h00, 5'd12, 1, 32'h0000_3024, 32'h0,         1, 5'd13, 32'h8000_0030, 32'h0000_3020});
      vecs.push_back(vec_t'{0, 1, 5'd0,  32'h0,         6'h00, 5'd0,  0, 32'h0000_3028, 32'h0,         0, 5'd14, 32'h0000_3020, 32'h0000_3020});
      vecs.push_back(vec_t'{0, 0, 5'd0,  32'h0,         6'h01, 5'd10, 0, 32'h0000_3040, 32'h0,         1, 5'd13, 32'h0000_0400, 32'h0000_3040});
      vecs.push_back(vec_t'{0, 0, 5'd0,  32'h0,         6'h00, 5'd8,  0, 32'h0000_5000, 32'h0,         0, 5'd14, 32'h0000_3040, 32'h0000_3040});
      vecs.push_back(vec_t'{0, 1, 5'd0,  32'h0,         6'h00, 5'd0,  0, 32'h0000_5004, 32'h0,         0, 5'd12, 32'h0000_0401, 32'h0000_3040});
      vecs.push_back(vec_t'{1, 0, 5'd14, 32'hDEAD_BEEF, 6'h00, 5'd4,  0, 32'h0000_6000, 32'h0000_0003, 1, 5'd14, 32'h0000_6000, 32'h0000_6000});
      vecs.push_back(vec_t'{0, 1, 5'd0,  32'h0,         6'h00, 5'd0,  0, 32'h0000_6004, 32'h0,         0, 5'd13, 32'h0000_0010, 32'h0000_6000});
      vecs.push_back(vec_t'{0, 0, 5'd0,  32'h0,         6'h00, 5'd12, 1, 32'h0000_0000, 32'h0000_1234, 1, 5'd14, 32'hFFFF_FFFC, 32'hFFFF_FFFC});
      vecs.push_back(vec_t'{0, 1, 5'd0,  32'h0,         6'h00, 5'd0,  0, 32'h0000_6008, 32'h0,         0, 5'd8,  BV_EXP,        32'hFFFF_FFFC});
      vecs.push_back(vec_t'{1, 0, 5'd13, 32'hFFFF_FFFF, 6'h00, 5'd0,  0, 32'h0000_600C, 32'h0,         0, 5'd13, 32'h8000_0030, 32'hFFFF_FFFC});
      vecs.push_back(vec_t'{1, 0, 5'd14, 32'h1234_5678, 6'h00, 5'd0,  0, 32'h0000_6010, 32'h0,         0, 5'd14, 32'h1234_5678, 32'h1234_5678});
      vecs.push_back(vec_t'{1, 0, 5'd12, 32'h0,         6'h02, 5'd0,  0, 32'h0000_6014, 32'h0,         0, 5'd12, 32'h0000_0000, 32'h1234_5678});
      vecs.push_back(vec_t'{0, 0, 5'd0,  32'h0,         6'h3F, 5'd0,  0, 32'h0000_6018, 32'h0,         0, 5'd13, 32'h8000_FC30, 32'h1234_5678});
      vecs.push_back(vec_t'{0, 0, 5'd0,  32'h0,         6'h00, 5'd0,  0, 32'h0000_601C, 32'h0,         0, 5'd3,  32'h0000_0000, 32'h1234_5678});
      vecs.push_back(vec_t'{1, 0, 5'd15, 32'hFFFF_FFFF, 6'h00, 5'd0,  0, 32'h0000_6020, 32'h0,         0, 5'd15, 32'h0000_2530, 32'h1234_5678});

      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("reset_req", {31'b0, req}, 32'h0);
      checkOutput("reset_epc_out", epc_out, 32'h0);
      m_rd = 5'd12; #1; checkOutput("reset_sr", cp0_rdata, 32'h0);
      m_rd = 5'd13; #1; checkOutput("reset_cause", cp0_rdata, 32'h0);
      m_rd = 5'd14; #1; checkOutput("reset_epc", cp0_rdata, 32'h0);
      m_rd = 5'd15; #1; checkOutput("reset_prid", cp0_rdata, 32'h0000_2530);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(i, vecs[i]);
      end

      // Enter a handler, then pulse reset between edges: state must clear without a clock edge.
      @(negedge clk);
      m_mtc0     = 1'b0;
      m_eret     = 1'b0;
      hw_int     = '0;
      m_bd       = 1'b0;
      m_exc_code = 5'd8;
      m_pc       = 32'h0000_7000;
      m_badvaddr = 32'h0000_0055;
      #1;
      checkOutput("seq_req", {31'b0, req}, 32'h1);
      @(posedge clk);
      #1;
      m_exc_code = 5'd0;
      m_rd       = 5'd12;
      #1;
      checkOutput("seq_sr_exl", cp0_rdata, 32'h0000_0002);
      checkOutput("seq_epc_out", epc_out, 32'h0000_7000);
      reset = 1'b1;
      #1;
      checkOutput("async_sr", cp0_rdata, 32'h0);
      checkOutput("async_epc_out", epc_out, 32'h0);
      m_rd = 5'd13; #1; checkOutput("async_cause", cp0_rdata, 32'h0);
      m_rd = 5'd8;  #1; checkOutput("async_badvaddr", cp0_rdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      m_rd = 5'd12; #1; checkOutput("post_reset_sr", cp0_rdata, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
